// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared state encoding and frame geometry for the UART boot loader.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        DATA = 3'd1,
        SUM  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_e;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/uart_loader_if.sv
// uart_loader_if: byte stream in, instruction-memory writes and load status out.
interface uart_loader_if #(parameter int ADDR_W = 12);

    logic              uart_re;
    logic [7:0]        rd_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              load_done;
    logic              load_err;

    modport master (
        output uart_re, rd_data,
        input  imem_we, imem_addr, imem_wdata, cpu_rst_n, load_done, load_err
    );

    modport slave (
        input  uart_re, rd_data,
        output imem_we, imem_addr, imem_wdata, cpu_rst_n, load_done, load_err
    );

endinterface

// File: rtl/uart_loader_byte_packer.sv
// uart_loader_byte_packer: packs bytes little-endian into 32-bit words.
// word_o/word_valid_o are combinational on the strobe carrying the last byte of a word.
module uart_loader_byte_packer
    import uart_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        stb_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sh_q, sh_d;

    always_comb begin
        cnt_d = clr_i ? 2'd0 : stb_i ? cnt_q + 2'd1 : cnt_q;
        sh_d  = (stb_i && !clr_i) ? {byte_i, sh_q[23:8]} : sh_q;
    end

    assign word_valid_o = stb_i && !clr_i && cnt_q == 2'(WORD_BYTES - 1);
    assign word_o       = {byte_i, sh_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            sh_q  <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/uart_loader.sv
// uart_loader: parses a length-prefixed image from the UART, writes it to imem from
// word 0, and releases the CPU only once the payload checksum matches.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_loader_if.slave bus_io
);

    localparam logic [31:0] CAP = 32'(1) << ADDR_W;

    state_e            state_q;
    logic [ADDR_W:0]   len_q, wcnt_q, wcnt_d;
    logic [7:0]        sum_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, word;
    logic              we_q, cpu_rst_n_q, done_q, err_q, word_valid;

    // Header and payload share the packer: the header is itself one little-endian word.
    uart_loader_byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (state_q == DONE || state_q == ERR),
        .stb_i        (bus_io.uart_re && (state_q == HDR || state_q == DATA)),
        .byte_i       (bus_io.rd_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    assign wcnt_d = wcnt_q + (ADDR_W + 1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HDR;
            len_q       <= '0;
            wcnt_q      <= '0;
            sum_q       <= 8'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            we_q        <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            we_q <= 1'b0;
            // Advance after each write except the last, so the address never passes N-1.
            if (we_q && wcnt_q != len_q) addr_q <= addr_q + ADDR_W'(1);
            case (state_q)
                HDR: if (word_valid) begin
                    if (word > CAP) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else if (word == 32'd0) begin
                        state_q <= SUM;
                    end else begin
                        len_q   <= word[ADDR_W:0];
                        state_q <= DATA;
                    end
                end
                DATA: if (bus_io.uart_re) begin
                    sum_q <= sum_q + bus_io.rd_data;
                    if (word_valid) begin
                        we_q    <= 1'b1;
                        wdata_q <= word;
                        wcnt_q  <= wcnt_d;
                        if (wcnt_d == len_q) state_q <= SUM;
                    end
                end
                SUM: if (bus_io.uart_re) begin
                    if (bus_io.rd_data == sum_q) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        cpu_rst_n_q <= 1'b1;
                    end else begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_io.imem_we    = we_q;
    assign bus_io.imem_addr  = addr_q;
    assign bus_io.imem_wdata = wdata_q;
    assign bus_io.cpu_rst_n  = cpu_rst_n_q;
    assign bus_io.load_done  = done_q;
    assign bus_io.load_err   = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed frames with hand-computed writes, status and timing.
module tb_uart_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wr_count = 0;
    int   base;
    logic [11:0] log_a [16];
    logic [31:0] log_d [16];
    int          log_t [16];
    logic [7:0]  fa [13];

    uart_loader_if #(.ADDR_W(12)) bus ();

    uart_loader #(.ADDR_W(12)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (wr_count < 16) begin
                log_a[wr_count] = bus.imem_addr;
                log_d[wr_count] = bus.imem_wdata;
                log_t[wr_count] = cyc;
            end
            wr_count = wr_count + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.uart_re = 1'b1;
        bus.rd_data = b;
        @(posedge clk);
        #1;
        bus.uart_re = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        bus.uart_re = 1'b0;
        bus.rd_data = 8'h00;
        fa = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};

        // reset only
        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("reset_idle", {28'd0, bus.imem_we, bus.cpu_rst_n, bus.load_done, bus.load_err}, 32'd0);
        end
        check("reset_addr", {20'd0, bus.imem_addr}, 32'd0);
        check("reset_wdata", bus.imem_wdata, 32'd0);
        check("reset_writes", wr_count, 0);

        // good frame with gaps, write pulse timing
        base = wr_count;
        for (int i = 0; i < 7; i++) begin
            send(fa[i]);
            idle(2);
        end
        send(fa[7]);
        @(negedge clk);
        check("w0_we", {31'd0, bus.imem_we}, 32'd1);
        check("w0_addr", {20'd0, bus.imem_addr}, 32'd0);
        check("w0_data", bus.imem_wdata, 32'h00000013);
        @(negedge clk);
        check("w0_we_drop", {31'd0, bus.imem_we}, 32'd0);
        check("w0_addr_inc", {20'd0, bus.imem_addr}, 32'd1);
        check("w0_data_hold", bus.imem_wdata, 32'h00000013);
        for (int i = 8; i < 12; i++) begin
            send(fa[i]);
            idle(1);
        end
        check("pre_sum_done", {30'd0, bus.load_done, bus.cpu_rst_n}, 32'd0);
        send(fa[12]);
        @(negedge clk);
        check("ok_done", {29'd0, bus.load_done, bus.cpu_rst_n, bus.load_err}, 32'b110);
        check("ok_writes", wr_count - base, 2);
        check("ok_a0", {20'd0, log_a[base]}, 32'd0);
        check("ok_d0", log_d[base], 32'h00000013);
        check("ok_a1", {20'd0, log_a[base+1]}, 32'd1);
        check("ok_d1", log_d[base+1], 32'h00100093);
        check("ok_addr_max", {20'd0, bus.imem_addr}, 32'd1);

        // bad checksum, then ignored bytes
        do_reset();
        base = wr_count;
        for (int i = 0; i < 12; i++) send(fa[i]);
        send(8'hB7);
        @(negedge clk);
        check("bad_status", {29'd0, bus.load_done, bus.cpu_rst_n, bus.load_err}, 32'b001);
        check("bad_writes", wr_count - base, 2);
        for (int i = 4; i < 12; i++) send(fa[i]);
        idle(3);
        check("bad_no_more_writes", wr_count - base, 2);
        check("bad_status_hold", {29'd0, bus.load_done, bus.cpu_rst_n, bus.load_err}, 32'b001);

        // oversize header N = 4097
        do_reset();
        base = wr_count;
        send(8'h01);
        send(8'h10);
        send(8'h00);
        @(negedge clk);
        check("big_err_early", {31'd0, bus.load_err}, 32'd0);
        send(8'h00);
        @(negedge clk);
        check("big_err", {29'd0, bus.load_done, bus.cpu_rst_n, bus.load_err}, 32'b001);
        for (int i = 4; i < 8; i++) send(fa[i]);
        idle(2);
        check("big_writes", wr_count - base, 0);

        // N = 4096 is accepted
        do_reset();
        send(8'h00);
        send(8'h10);
        send(8'h00);
        send(8'h00);
        @(negedge clk);
        check("cap_no_err", {31'd0, bus.load_err}, 32'd0);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        send(8'hDD);
        @(negedge clk);
        check("cap_we", {31'd0, bus.imem_we}, 32'd1);
        check("cap_data", bus.imem_wdata, 32'hDDCCBBAA);
        check("cap_addr", {20'd0, bus.imem_addr}, 32'd0);

        // empty image, checksum 00
        do_reset();
        base = wr_count;
        repeat (5) send(8'h00);
        @(negedge clk);
        check("empty_ok", {29'd0, bus.load_done, bus.cpu_rst_n, bus.load_err}, 32'b110);
        check("empty_writes", wr_count - base, 0);

        // empty image, checksum 01
        do_reset();
        repeat (4) send(8'h00);
        send(8'h01);
        @(negedge clk);
        check("empty_bad", {29'd0, bus.load_done, bus.cpu_rst_n, bus.load_err}, 32'b001);

        // back-to-back bytes
        do_reset();
        base = wr_count;
        for (int i = 0; i < 13; i++) send(fa[i]);
        @(negedge clk);
        check("burst_done", {29'd0, bus.load_done, bus.cpu_rst_n, bus.load_err}, 32'b110);
        check("burst_writes", wr_count - base, 2);
        check("burst_a0", {20'd0, log_a[base]}, 32'd0);
        check("burst_d0", log_d[base], 32'h00000013);
        check("burst_a1", {20'd0, log_a[base+1]}, 32'd1);
        check("burst_d1", log_d[base+1], 32'h00100093);
        check("burst_spacing", log_t[base+1] - log_t[base], 4);

        // asynchronous reassertion of cpu_rst_n
        idle(1);
        rst_n = 1'b0;
        #2;
        check("async_cpu_rst", {30'd0, bus.cpu_rst_n, bus.load_done}, 32'd0);
        idle(1);
        rst_n = 1'b1;
        idle(1);

        // partial frame with one write, reset mid-frame, then a fresh frame
        send(8'h02);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        send(8'hDD);
        send(8'hEE);
        idle(1);
        check("partial_addr", {20'd0, bus.imem_addr}, 32'd1);
        do_reset();
        base = wr_count;
        send(8'h01);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        send(8'h0A);
        @(negedge clk);
        check("fresh_done", {29'd0, bus.load_done, bus.cpu_rst_n, bus.load_err}, 32'b110);
        check("fresh_writes", wr_count - base, 1);
        check("fresh_a0", {20'd0, log_a[base]}, 32'd0);
        check("fresh_d0", log_d[base], 32'h04030201);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
